ft245_rx_capture: RTL and testbench

//  FT245 synchronous-FIFO receive front end on ftdi_clk. Owns OE#/RD#, captures host bytes into a small skid FIFO
//  and drains them into the write side of the inbound ping-pong FIFO. Each entry is tagged with a start-of-frame bit.

---
 rtl/ft_pkg.sv | 35 +++
 rtl/ft_rx_skid_fifo.sv | 60 ++++++
 rtl/ft245_rx_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_ft245_rx_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared definitions for the FT245 receive front end: FSM state encodings,
// FIFO entry layout and the buffer-claim helper.
package ft_pkg;

  // Read FSM owning OE#/RD# and the shared data bus
  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_TURN    = 2'd1,
    RD_READ    = 2'd2,
    RD_RELEASE = 2'd3
  } rd_state_t;

  // Drain FSM feeding the ping-pong buffer write port
  typedef enum logic [0:0] {
    DR_IDLE = 1'b0,
    DR_FILL = 1'b1
  } dr_state_t;

  localparam int ENTRY_W = 9;
  localparam int SOF_BIT = 8;

  // Buffer 0 wins when both ping-pong halves are available
  function automatic logic [1:0] claim_buffer(input logic [1:0] ready);
    logic [1:0] grant;
    if (ready[0]) begin
      grant = 2'b01;
    end else if (ready[1]) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
    return grant;
  endfunction

endpackage

// File: rtl/ft_rx_skid_fifo.sv
// Small synchronous skid FIFO (DEPTH x 9) between the FT245 capture point and
// the ping-pong buffer drain. Simultaneous push and pop are both honoured.
module ft_rx_skid_fifo
  import ft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic [OCC_W-1:0]   o_occ,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_occ == OCC_W'(DEPTH));
  assign o_empty   = (r_occ == {OCC_W{1'b0}});
  assign o_occ     = r_occ;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // Entry storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_occ    <= {OCC_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/ft245_rx_capture.sv
// FT245 synchronous-FIFO receive front end. Drives OE#/RD#, captures host bytes
// into a skid FIFO tagged with a start-of-frame bit, and drains them into the
// inbound ping-pong buffer. Optional macro FT_RX_HOLDOFF_EN delays release of a
// partially filled buffer until RXF# has been high for HOLDOFF_CYCLES cycles.
module ft245_rx_capture
  import ft_pkg::*;
#(
  parameter int SKID_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic               ftdi_clk,
  input  logic               rst,
  input  logic [7:0]         ftdi_data_in,
  input  logic               ftdi_rxf_n,
  output logic               ftdi_oe_n,
  output logic               ftdi_rd_n,
  output logic               bus_req,
  input  logic               bus_grant,
  output logic               bus_busy,
  input  logic [1:0]         fifo_write_ready,
  output logic [1:0]         fifo_write_activate,
  input  logic [23:0]        fifo_write_size,
  output logic               fifo_write_strobe,
  output logic [ENTRY_W-1:0] fifo_write_data,
  output logic               overflow_err
);

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_REQ_MAX = OCC_W'(SKID_DEPTH - 2);
  localparam logic [OCC_W-1:0] OCC_RD_MAX  = OCC_W'(SKID_DEPTH - 1);

  rd_state_t          r_rd_state;
  dr_state_t          r_dr_state;
  logic               r_oe_n, r_rd_n, r_bus_req, r_bus_busy;
  logic               r_rxf_prev, r_sof_flag, r_overflow_err;
  logic [1:0]         r_activate;
  logic [23:0]        r_count, r_size;
  logic               r_strobe;
  logic [ENTRY_W-1:0] r_data;

  logic               w_capture, w_rxf_fall, w_pop, w_full, w_empty;
  logic               w_req_cond, w_rd_allow, w_idle_release;
  logic [ENTRY_W-1:0] w_push_data, w_head;
  logic [OCC_W-1:0]   w_occ, w_occ_next;

  assign ftdi_oe_n           = r_oe_n;
  assign ftdi_rd_n           = r_rd_n;
  assign bus_req             = r_bus_req;
  assign bus_busy            = r_bus_busy;
  assign fifo_write_activate = r_activate;
  assign fifo_write_strobe   = r_strobe;
  assign fifo_write_data     = r_data;
  assign overflow_err        = r_overflow_err;

  // A byte is taken on every edge where our registered RD# and RXF# are both low
  assign w_capture  = ~r_rd_n & ~ftdi_rxf_n;
  assign w_rxf_fall = r_rxf_prev & ~ftdi_rxf_n;
  assign w_pop      = (r_dr_state == DR_FILL) & ~w_empty & (r_count < r_size);
  assign w_req_cond = ~ftdi_rxf_n & (w_occ <= OCC_REQ_MAX);
  // Keep reading only while the byte captured next edge is guaranteed a slot
  assign w_rd_allow = (w_occ_next <= OCC_RD_MAX);

`ifdef FT_RX_HOLDOFF_EN
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_CYCLES);
  logic [HOLD_W-1:0] r_hold_cnt;

  // Count consecutive idle RXF# cycles, saturating at the holdoff time
  always_ff @(posedge ftdi_clk) begin
    if (rst || !ftdi_rxf_n) begin
      r_hold_cnt <= {HOLD_W{1'b0}};
    end else if (r_hold_cnt != HOLD_MAX) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  assign w_idle_release = (r_rd_state == RD_IDLE) & ftdi_rxf_n & w_empty &
                          (r_count != 24'd0) & (r_hold_cnt == HOLD_MAX);
`else
  localparam int HOLDOFF_UNUSED = HOLDOFF_CYCLES;
  assign w_idle_release = (r_rd_state == RD_IDLE) & ftdi_rxf_n & w_empty &
                          (r_count != 24'd0);
`endif

  // Build the skid entry: host byte plus start-of-frame tag
  always_comb begin
    w_push_data          = {1'b0, ftdi_data_in};
    w_push_data[SOF_BIT] = r_sof_flag | w_rxf_fall;
  end

  // Occupancy as it will stand after this edge's push/pop
  always_comb begin
    w_occ_next = w_occ;
    case ({w_capture, w_pop})
      2'b10:   w_occ_next = w_occ + OCC_W'(1);
      2'b01:   w_occ_next = w_occ - OCC_W'(1);
      default: w_occ_next = w_occ;
    endcase
  end

  ft_rx_skid_fifo #(.DEPTH(SKID_DEPTH), .OCC_W(OCC_W)) u_skid (
    .clk         (ftdi_clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Read FSM: bus arbitration, OE# turnaround and flow-controlled RD#
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
      r_oe_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_bus_req  <= 1'b0;
      r_bus_busy <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          r_rd_n <= 1'b1;
          if (w_req_cond && bus_grant) begin
            r_rd_state <= RD_TURN;
            r_oe_n     <= 1'b0;
            r_bus_busy <= 1'b1;
            r_bus_req  <= 1'b1;
          end else begin
            r_oe_n     <= 1'b1;
            r_bus_busy <= 1'b0;
            r_bus_req  <= w_req_cond;
          end
        end
        RD_TURN: begin
          r_rd_state <= RD_READ;
          r_rd_n     <= ~w_rd_allow;
        end
        RD_READ: begin
          if (ftdi_rxf_n || (w_full && (r_dr_state == DR_IDLE))) begin
            r_rd_state <= RD_RELEASE;
            r_rd_n     <= 1'b1;
            r_bus_req  <= 1'b0;
          end else begin
            r_rd_n <= ~w_rd_allow;
          end
        end
        RD_RELEASE: begin
          r_rd_state <= RD_IDLE;
          r_rd_n     <= 1'b1;
          r_oe_n     <= 1'b1;
          r_bus_busy <= 1'b0;
          r_bus_req  <= 1'b0;
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_rd_n     <= 1'b1;
          r_oe_n     <= 1'b1;
          r_bus_busy <= 1'b0;
          r_bus_req  <= 1'b0;
        end
      endcase
    end
  end

  // SOF tracker and sticky overflow flag; a capture on the fall edge keeps sof
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_rxf_prev     <= 1'b1;
      r_sof_flag     <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_rxf_prev <= ftdi_rxf_n;
      if (w_capture) begin
        r_sof_flag <= 1'b0;
      end else if (w_rxf_fall) begin
        r_sof_flag <= 1'b1;
      end
      if (w_capture && w_full) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Drain FSM: claim a ping-pong buffer, fill it from the skid FIFO, release it
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_dr_state <= DR_IDLE;
      r_activate <= 2'b00;
      r_count    <= 24'd0;
      r_size     <= 24'd0;
      r_strobe   <= 1'b0;
      r_data     <= {ENTRY_W{1'b0}};
    end else begin
      r_strobe <= w_pop;
      if (w_pop) begin
        r_data <= w_head;
      end
      case (r_dr_state)
        DR_IDLE: begin
          if (fifo_write_ready != 2'b00) begin
            r_activate <= claim_buffer(fifo_write_ready);
            r_count    <= 24'd0;
            r_size     <= fifo_write_size;
            r_dr_state <= DR_FILL;
          end else begin
            r_activate <= 2'b00;
          end
        end
        DR_FILL: begin
          if (w_pop) begin
            r_count <= r_count + 24'd1;
          end else if ((r_count == r_size) || w_idle_release) begin
            r_activate <= 2'b00;
            r_dr_state <= DR_IDLE;
          end
        end
        default: begin
          r_activate <= 2'b00;
          r_dr_state <= DR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_rx_capture.sv
// Scoreboard bench for ft245_rx_capture: an FT245 host model feeds bytes,
// expected buffer writes are queued when each burst is issued, and a monitor
// compares every write strobe against the queue head.
module tb_ft245_rx_capture;

  logic        ftdi_clk = 1'b0;
  logic        rst;
  logic [7:0]  ftdi_data_in;
  logic        ftdi_rxf_n;
  logic        ftdi_oe_n, ftdi_rd_n, bus_req, bus_busy;
  logic        bus_grant;
  logic [1:0]  fifo_write_ready, fifo_write_activate;
  logic [23:0] fifo_write_size;
  logic        fifo_write_strobe;
  logic [8:0]  fifo_write_data;
  logic        overflow_err;

  typedef struct { logic [7:0] data; int gap; } ft_byte_t;
  typedef struct { logic [8:0] data; logic [1:0] act; } exp_t;

  ft_byte_t ft_q[$];
  exp_t     exp_q[$];
  exp_t     mon_e;
  ft_byte_t hd;
  int       n_vec = 0;
  int       n_err = 0;
  int       gap_cnt = 0;
  logic     cap;

  always #5 ftdi_clk = ~ftdi_clk;

  ft245_rx_capture #(.SKID_DEPTH(4), .HOLDOFF_CYCLES(8)) dut (
    .ftdi_clk            (ftdi_clk),
    .rst                 (rst),
    .ftdi_data_in        (ftdi_data_in),
    .ftdi_rxf_n          (ftdi_rxf_n),
    .ftdi_oe_n           (ftdi_oe_n),
    .ftdi_rd_n           (ftdi_rd_n),
    .bus_req             (bus_req),
    .bus_grant           (bus_grant),
    .bus_busy            (bus_busy),
    .fifo_write_ready    (fifo_write_ready),
    .fifo_write_activate (fifo_write_activate),
    .fifo_write_size     (fifo_write_size),
    .fifo_write_strobe   (fifo_write_strobe),
    .fifo_write_data     (fifo_write_data),
    .overflow_err        (overflow_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every write strobe is compared with the scoreboard head
  always @(negedge ftdi_clk) begin
    if (!rst && fifo_write_strobe) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got data %0h, expected no write", fifo_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_data", {23'd0, fifo_write_data}, {23'd0, mon_e.data});
        check("wr_activate", {30'd0, fifo_write_activate}, {30'd0, mon_e.act});
      end
    end
  end

  // FT245 host model: a byte is consumed on each edge with RD# and RXF# low
  initial begin
    ftdi_rxf_n   = 1'b0;
    ftdi_data_in = 8'h00;
    forever begin
      @(posedge ftdi_clk);
      if (!rst) begin
        cap = !ftdi_rd_n && !ftdi_rxf_n;
        #1;
        if (cap && ft_q.size() > 0) begin
          void'(ft_q.pop_front());
          if (ft_q.size() > 0 && ft_q[0].gap > 0) begin
            hd       = ft_q[0];
            gap_cnt  = hd.gap;
            hd.gap   = 0;
            ft_q[0]  = hd;
          end
        end
        if (gap_cnt > 0) begin
          ftdi_rxf_n = 1'b1;
          gap_cnt--;
        end else begin
          ftdi_rxf_n = (ft_q.size() == 0);
        end
        ftdi_data_in = (ft_q.size() > 0) ? ft_q[0].data : 8'h00;
      end
    end
  end

  // Queue a burst: byte i = first+i; sof on byte 0 and on the byte after a gap;
  // bytes from index split onward are expected in buffer act_b.
  task automatic push_burst(input logic [7:0] first, input int n, input int gap_idx,
                            input int gap_len, input int split,
                            input logic [1:0] act_a, input logic [1:0] act_b);
    exp_t     e;
    ft_byte_t b;
    for (int i = 0; i < n; i++) begin
      e.data = {((i == 0) || (i == gap_idx && gap_len > 0)) ? 1'b1 : 1'b0, first + 8'(i)};
      e.act  = (i >= split) ? act_b : act_a;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      b.data = first + 8'(i);
      b.gap  = (i == gap_idx) ? gap_len : 0;
      ft_q.push_back(b);
    end
  endtask

  task automatic wait_act(input logic [1:0] v, input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge ftdi_clk);
      if (fifo_write_activate == v) break;
    end
    check(name, {30'd0, fifo_write_activate}, {30'd0, v});
  endtask

  task automatic wait_drained(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge ftdi_clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus_grant        = 1'b0;
    fifo_write_ready = 2'b00;
    fifo_write_size  = 24'd0;

    // Reset with RXF# low
    repeat (3) @(negedge ftdi_clk);
    check("rst_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("rst_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
    check("rst_activate", {30'd0, fifo_write_activate}, 32'd0);
    check("rst_strobe", {31'd0, fifo_write_strobe}, 32'd0);
    check("rst_overflow", {31'd0, overflow_err}, 32'd0);
    rst = 1'b0;
    @(negedge ftdi_clk);

    // 10-byte burst into buffer 0, OE# leads RD# by one cycle
    bus_grant        = 1'b1;
    fifo_write_size  = 24'd1024;
    fifo_write_ready = 2'b01;
    wait_act(2'b01, "claim_b0");
    fifo_write_ready = 2'b00;
    push_burst(8'h00, 10, -1, 0, 99, 2'b01, 2'b01);
    for (int k = 0; k < 50; k++) begin
      @(negedge ftdi_clk);
      if (!ftdi_oe_n) break;
    end
    check("oe_fall", {31'd0, ftdi_oe_n}, 32'd0);
    check("rd_n_turn", {31'd0, ftdi_rd_n}, 32'd1);
    @(negedge ftdi_clk);
    check("rd_n_read", {31'd0, ftdi_rd_n}, 32'd0);
    wait_drained("burst10_drained");
    wait_act(2'b00, "burst10_release");

    // size=4, 6 bytes: 4 to buffer 0, 2 to buffer 1
    fifo_write_size  = 24'd4;
    fifo_write_ready = 2'b11;
    wait_act(2'b01, "size4_claim_b0");
    fifo_write_ready = 2'b10;
    push_burst(8'h00, 6, -1, 0, 4, 2'b01, 2'b10);
    wait_act(2'b10, "size4_claim_b1");
    fifo_write_ready = 2'b00;
    wait_drained("size4_drained");
    wait_act(2'b00, "size4_release");
    check("size4_overflow", {31'd0, overflow_err}, 32'd0);

    // No buffer ready during a 20-byte burst: skid fills, bus is released
    fifo_write_size = 24'd1024;
    push_burst(8'h10, 20, -1, 0, 99, 2'b01, 2'b01);
    for (int k = 0; k < 50; k++) begin
      @(negedge ftdi_clk);
      if (bus_busy) break;
    end
    check("stall_busy_on", {31'd0, bus_busy}, 32'd1);
    for (int k = 0; k < 50; k++) begin
      @(negedge ftdi_clk);
      if (!bus_busy) break;
    end
    check("stall_busy_off", {31'd0, bus_busy}, 32'd0);
    check("stall_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("stall_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("stall_no_writes", exp_q.size(), 32'd20);
    check("stall_skid_left", ft_q.size(), 32'd16);
    repeat (5) @(negedge ftdi_clk);
    check("stall_bus_req", {31'd0, bus_req}, 32'd0);
    fifo_write_ready = 2'b01;
    wait_act(2'b01, "stall_claim");
    fifo_write_ready = 2'b00;
    wait_drained("stall_drained");
    wait_act(2'b00, "stall_release");
    check("stall_overflow", {31'd0, overflow_err}, 32'd0);

    // One-cycle RXF# gap mid-burst re-tags the next byte as sof
    fifo_write_ready = 2'b01;
    wait_act(2'b01, "sof_claim");
    fifo_write_ready = 2'b00;
    push_burst(8'h30, 8, 4, 1, 99, 2'b01, 2'b01);
    wait_drained("sof_drained");
    wait_act(2'b00, "sof_release");

`ifdef FT_RX_HOLDOFF_EN
    // 5-cycle gap keeps one buffer; a long idle releases it
    fifo_write_ready = 2'b01;
    wait_act(2'b01, "hold_claim");
    fifo_write_ready = 2'b00;
    push_burst(8'h40, 8, 4, 5, 99, 2'b01, 2'b01);
    wait_drained("hold_drained");
    check("hold_kept", {30'd0, fifo_write_activate}, 32'd1);
    wait_act(2'b00, "hold_release");
`endif

    check("final_overflow", {31'd0, overflow_err}, 32'd0);
    repeat (5) @(negedge ftdi_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
